// File: rtl/ssd_display_driver.sv
// Register-value display driver: clamps a 32-bit value to 0..9999, converts it to BCD with a
// sequential double-dabble engine and scans four common-anode digits. Optional: SSD_BLANK_EN.
module ssd_display_driver #(
    parameter int unsigned SCAN_DIV = 10000
) (
    input  logic        fastclk,
    input  logic        reset,
    input  logic [31:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [3:0]  tho,
    output logic [3:0]  hun,
    output logic [3:0]  ten,
    output logic [3:0]  one,
    output logic        busy,
    output logic        overflow
);

    localparam logic [31:0] MaxValue  = 32'd9999;
    localparam logic [13:0] MaxClamp  = 14'd9999;
    localparam logic [3:0]  LastIter  = 4'd13;
    localparam int unsigned ScanWidth = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScanWidth-1:0] ScanLast = ScanWidth'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLoad
    } state_e;

    // Adds 3 to every BCD nibble that is 5 or more, ahead of the doubling shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    logic        value_ovf;
    logic [13:0] value_clamp;
    logic [13:0] value_q;
    logic        ovf_q;

    always_comb begin
        value_ovf   = (value > MaxValue);
        value_clamp = value_ovf ? MaxClamp : value[13:0];
    end

    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_clamp;
            ovf_q   <= value_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [13:0] conv_src_q, conv_src_d;
    logic        ovf_conv_q, ovf_conv_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] bin_q, bin_d;
    logic [3:0]  iter_q, iter_d;
    logic [3:0]  tho_d, hun_d, ten_d, one_d;
    logic        overflow_d;
    logic [15:0] bcd_adj;

    always_comb begin
        state_d    = state_q;
        conv_src_d = conv_src_q;
        ovf_conv_d = ovf_conv_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        iter_d     = iter_q;
        tho_d      = tho;
        hun_d      = hun;
        ten_d      = ten;
        one_d      = one;
        overflow_d = overflow;
        bcd_adj    = dabble_adjust(bcd_q);

        case (state_q)
            StIdle: begin
                // Compare against the committed overflow too, so 9999 -> >9999 still recommits.
                if ((value_q != conv_src_q) || (ovf_q != overflow)) begin
                    conv_src_d = value_q;
                    ovf_conv_d = ovf_q;
                    bcd_d      = '0;
                    bin_d      = value_q;
                    iter_d     = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                iter_d         = iter_q + 4'd1;
                if (iter_q == LastIter) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                tho_d      = bcd_q[15:12];
                hun_d      = bcd_q[11:8];
                ten_d      = bcd_q[7:4];
                one_d      = bcd_q[3:0];
                overflow_d = ovf_conv_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            conv_src_q <= '0;
            ovf_conv_q <= 1'b0;
            bcd_q      <= '0;
            bin_q      <= '0;
            iter_q     <= '0;
            tho        <= '0;
            hun        <= '0;
            ten        <= '0;
            one        <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_src_q <= conv_src_d;
            ovf_conv_q <= ovf_conv_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            iter_q     <= iter_d;
            tho        <= tho_d;
            hun        <= hun_d;
            ten        <= ten_d;
            one        <= one_d;
            overflow   <= overflow_d;
        end
    end

    assign busy = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Digit scan: prescaler and ring index run independently of the converter
    // ------------------------------------------------------------------
    logic [ScanWidth-1:0] scan_cnt_q;
    logic [1:0]           digit_idx_q;
    logic                 scan_wrap;

    assign scan_wrap = (scan_cnt_q == ScanLast);

    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else if (scan_wrap) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= digit_idx_q + 2'd1;
        end else begin
            scan_cnt_q  <= scan_cnt_q + 1'b1;
        end
    end

    logic [3:0] digit_sel;
    logic       blank;

    always_comb begin
        anode = ~(4'b0001 << digit_idx_q);
        case (digit_idx_q)
            2'd0:    digit_sel = one;
            2'd1:    digit_sel = ten;
            2'd2:    digit_sel = hun;
            default: digit_sel = tho;
        endcase
`ifdef SSD_BLANK_EN
        // Leading-zero suppression; the ones digit always shows.
        case (digit_idx_q)
            2'd3:    blank = (tho == 4'd0);
            2'd2:    blank = (tho == 4'd0) && (hun == 4'd0);
            2'd1:    blank = (tho == 4'd0) && (hun == 4'd0) && (ten == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        seg = blank ? 7'b1111111 : seg_decode(digit_sel);
    end

endmodule
